// File: rtl/synth_pkg.sv
// Shared MIDI constants and parser state encoding for the synth front end.
package synth_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] BEND     = 4'hE;

    localparam logic [6:0]  CC_ALL_NOTES_OFF = 7'd123;
    localparam logic [13:0] BEND_CENTRE      = 14'd8192;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_D1 = 2'd1;
    localparam logic [1:0] WAIT_D2 = 2'd2;

endpackage

// File: rtl/midi_byte_classifier.sv
// Combinational decode of one MIDI byte into its class and, for channel
// status bytes, the number of data bytes the message carries.
module midi_byte_classifier
    import synth_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       is_data,
    output logic       is_chan,
    output logic       is_sys,
    output logic       is_rt,
    output logic [1:0] data_len
);

    always_comb begin
        is_data = ~rx_data[7];
        is_chan = rx_data[7] && (rx_data[7:4] != 4'hF);
        is_sys  = (rx_data[7:3] == 5'b11110);
        is_rt   = (rx_data[7:3] == 5'b11111);
        // Program change and channel aftertouch are the only one-data-byte types
        data_len = ((rx_data[7:4] == PROG) || (rx_data[7:4] == CH_AT)) ? 2'd1 : 2'd2;
    end

endmodule

// File: rtl/midi_note_parser.sv
// MIDI channel-voice parser: running-status byte framing plus monophonic
// note/velocity/gate and pitch-bend tracking for the oscillator and envelope.
module midi_note_parser
    import synth_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [6:0]  note,
    output logic [6:0]  velocity,
    output logic        gate,
    output logic        note_on_pulse,
    output logic        note_off_pulse,
    output logic [13:0] pitch_bend
);

    localparam logic [3:0] CH = 4'(CHANNEL);

    logic       is_data, is_chan, is_sys, is_rt;
    logic [1:0] data_len;

    midi_byte_classifier u_cls (
        .rx_data  (rx_data),
        .is_data  (is_data),
        .is_chan  (is_chan),
        .is_sys   (is_sys),
        .is_rt    (is_rt),
        .data_len (data_len)
    );

    logic [1:0] state;
    logic [3:0] run_type;
    logic [3:0] run_chan;
    logic       run_two;
    logic [6:0] d1;

    // Realtime bytes are transparent: they never reach the framing logic
    logic byte_ok;
    assign byte_ok = rx_valid && !is_rt;

    logic chan_ok;
    assign chan_ok = OMNI || (run_chan == CH);

    logic       done;
    logic [6:0] msg_d1, msg_d2;

    always_comb begin
        done   = 1'b0;
        msg_d1 = d1;
        msg_d2 = rx_data[6:0];
        if (byte_ok && is_data) begin
            if (state == WAIT_D1 && !run_two) begin
                done   = 1'b1;
                msg_d1 = rx_data[6:0];
                msg_d2 = 7'd0;
            end else if (state == WAIT_D2) begin
                done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            run_type <= 4'd0;
            run_chan <= 4'd0;
            run_two  <= 1'b0;
            d1       <= 7'd0;
        end else if (byte_ok) begin
            if (is_sys) begin
                state <= IDLE;
            end else if (is_chan) begin
                run_type <= rx_data[7:4];
                run_chan <= rx_data[3:0];
                run_two  <= (data_len == 2'd2);
                state    <= WAIT_D1;
            end else if (is_data) begin
                case (state)
                    WAIT_D1: if (run_two) begin
                        d1    <= rx_data[6:0];
                        state <= WAIT_D2;
                    end
                    WAIT_D2: state <= WAIT_D1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note           <= 7'd0;
            velocity       <= 7'd0;
            gate           <= 1'b0;
            note_on_pulse  <= 1'b0;
            note_off_pulse <= 1'b0;
            pitch_bend     <= BEND_CENTRE;
        end else begin
            note_on_pulse  <= 1'b0;
            note_off_pulse <= 1'b0;
            if (done && chan_ok) begin
                case (run_type)
                    NOTE_ON, NOTE_OFF: begin
                        if (run_type == NOTE_ON && msg_d2 != 7'd0) begin
                            note          <= msg_d1;
                            velocity      <= msg_d2;
                            gate          <= 1'b1;
                            note_on_pulse <= 1'b1;
                        end else if (gate && msg_d1 == note) begin
                            gate           <= 1'b0;
                            note_off_pulse <= 1'b1;
                        end
                    end
                    CC: if (msg_d1 == CC_ALL_NOTES_OFF && gate) begin
                        gate           <= 1'b0;
                        note_off_pulse <= 1'b1;
                    end
                    BEND: pitch_bend <= {msg_d2, msg_d1};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_note_parser.sv
// Scoreboard bench: a queue-based MIDI message model predicts the outputs of
// every cycle; a monitor compares them against the parser one cycle later.
module tb_midi_note_parser;

    localparam int CH   = 0;
    localparam bit OMNI = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic [6:0]  note, velocity;
    logic        gate, note_on_pulse, note_off_pulse;
    logic [13:0] pitch_bend;

    midi_note_parser #(.CHANNEL(CH), .OMNI(OMNI)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .note           (note),
        .velocity       (velocity),
        .gate           (gate),
        .note_on_pulse  (note_on_pulse),
        .note_off_pulse (note_off_pulse),
        .pitch_bend     (pitch_bend)
    );

    always #5 clk = ~clk;

    typedef struct {
        int note;
        int vel;
        int gate;
        int on;
        int off;
        int bend;
    } snap_t;

    snap_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a message is a status byte plus a list of data bytes
    int m_status;
    int dq[$];
    int m_note, m_vel, m_gate, m_on, m_off, m_bend;

    function automatic int msg_len(input int st);
        return (((st >> 4) == 12) || ((st >> 4) == 13)) ? 1 : 2;
    endfunction

    task automatic model_reset();
        m_status = -1;
        dq.delete();
        m_note = 0; m_vel = 0; m_gate = 0; m_on = 0; m_off = 0; m_bend = 8192;
    endtask

    task automatic model_exec();
        int kind, a, b;
        kind = m_status >> 4;
        a = dq[0];
        b = (dq.size() > 1) ? dq[1] : 0;
        if (!OMNI && (m_status & 15) != CH) return;
        if (kind == 9 && b != 0) begin
            m_note = a; m_vel = b; m_gate = 1; m_on = 1;
        end else if (kind == 8 || kind == 9) begin
            if (m_gate == 1 && a == m_note) begin m_gate = 0; m_off = 1; end
        end else if (kind == 11) begin
            if (a == 123 && m_gate == 1) begin m_gate = 0; m_off = 1; end
        end else if (kind == 14) begin
            m_bend = b * 128 + a;
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        int x;
        m_on = 0; m_off = 0;
        if (!v) return;
        x = int'(b);
        if (x >= 'hF8) begin
        end else if (x >= 'hF0) begin
            m_status = -1; dq.delete();
        end else if (x >= 'h80) begin
            m_status = x; dq.delete();
        end else if (m_status >= 0) begin
            dq.push_back(x);
            if (dq.size() == msg_len(m_status)) begin
                model_exec();
                dq.delete();
            end
        end
    endtask

    function automatic snap_t cur_snap();
        snap_t s;
        s.note = m_note; s.vel = m_vel; s.gate = m_gate;
        s.on = m_on; s.off = m_off; s.bend = m_bend;
        return s;
    endfunction

    task automatic drive(input logic v, input logic [7:0] b);
        @(negedge clk);
        rx_valid = v;
        rx_data  = b;
        model_step(v, b);
        exp_q.push_back(cur_snap());
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rx_valid = 1'b0;
        model_reset();
        exp_q.push_back(cur_snap());
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(cur_snap());
    endtask

    always @(posedge clk) begin
        snap_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (int'(note) != e.note || int'(velocity) != e.vel || int'(gate) != e.gate ||
                int'(note_on_pulse) != e.on || int'(note_off_pulse) != e.off ||
                int'(pitch_bend) != e.bend) begin
                n_bad++;
                $display("FAIL outputs @%0t: got note=%0d vel=%0d gate=%0d on=%0d off=%0d bend=%0d, want note=%0d vel=%0d gate=%0d on=%0d off=%0d bend=%0d",
                         $time, note, velocity, gate, note_on_pulse, note_off_pulse, pitch_bend,
                         e.note, e.vel, e.gate, e.on, e.off, e.bend);
            end
        end
    end

    function automatic logic [7:0] rand_byte();
        int r, q;
        logic [3:0] kinds [9];
        kinds = '{4'h8, 4'h9, 4'h9, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hA};
        r = $urandom_range(0, 99);
        if (r < 9) begin
            q = $urandom_range(0, 9);
            return {kinds[$urandom_range(0, 8)], (q < 6) ? 4'd0 : (q < 9 ? 4'd1 : 4'($urandom_range(2, 15)))};
        end else if (r < 12) begin
            return 8'($urandom_range('hF0, 'hF7));
        end else if (r < 15) begin
            return 8'($urandom_range('hF8, 'hFF));
        end
        q = $urandom_range(0, 99);
        if (q < 50) return 8'($urandom_range(60, 62));
        if (q < 70) return 8'h00;
        if (q < 85) return 8'd123;
        return 8'($urandom_range(0, 127));
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        send(8'h90); send(8'h3C); send(8'h64); idle(1);
        send(8'h40); send(8'h50);
        send(8'h3C); send(8'h00);
        send(8'h40); send(8'h00); idle(1);

        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        send(8'h91); send(8'h3C); send(8'h64); idle(1);

        send(8'hE0); send(8'h00); send(8'h40);
        send(8'hE0); send(8'h7F); send(8'h7F);
        send(8'hB0); send(8'h7B); send(8'h00); idle(1);

        send(8'hF0); send(8'h3C); send(8'h64); send(8'hF7); send(8'h3C); send(8'h64);
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h90); send(8'h3C); send(8'h80); send(8'h3C); send(8'h00); idle(1);

        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h45); send(8'h64); idle(2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) drive(1'b0, 8'($urandom_range(0, 255)));
            else send(rand_byte());
            if (i == 1500) do_reset();
        end
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/midi_note_parser.md
Name: midi_note_parser

Overview:
- Byte-level MIDI channel-voice parser that converts a received MIDI stream into a monophonic note index, velocity and gate.
- Sits directly upstream of the note-to-frequency-step lookup: its 7-bit note output drives the lookup's index input, and gate/velocity go to the envelope stage.
- Fed by the UART receiver, one byte per rx_valid strobe.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) accepted when OMNI=0.
- OMNI, 0, 1 = accept channel-voice messages on all 16 channels.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received MIDI byte
- rx_valid  input  1  one-cycle strobe, rx_data valid
- note  output  7  current MIDI note number (feeds frequency-step lookup index)
- velocity  output  7  velocity of the most recent accepted note-on
- gate  output  1  1 while a note is held
- note_on_pulse  output  1  one-cycle strobe on every accepted note-on (including retrigger)
- note_off_pulse  output  1  one-cycle strobe when gate falls
- pitch_bend  output  14  latest pitch-bend value, 8192 = centre

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Outputs reset to note=0, velocity=0, gate=0, both pulses 0, pitch_bend=8192. Parser state goes to IDLE and running status is cleared. Assertion mid-message discards the partial message.
- Byte classes:
  - 0x00-0x7F: data.
  - 0x80-0xEF: channel status.
  - 0xF0-0xF7: system common.
  - 0xF8-0xFF: realtime.
- Realtime bytes are ignored completely: no state or running-status change, even mid-message.
- System common bytes clear running status and go to IDLE. Data bytes in IDLE are discarded, which covers SysEx payload.
- Channel status byte:
  - Latch status type and channel as running status.
  - Go to WAIT_D1.
  - If it arrives in WAIT_D1 or WAIT_D2, the partial message is aborted and the new status takes over.
- State machine:
  - IDLE -> WAIT_D1 on a channel status byte.
  - WAIT_D1 + data byte:
    - 1-byte types (0xCn, 0xDn): message complete, return to WAIT_D1 (running status).
    - Otherwise store d1 and go to WAIT_D2.
  - WAIT_D2 + data byte: message complete, back to WAIT_D1 (running status).
- Accepted on completion, only if channel matches CHANNEL or OMNI=1; otherwise the message is parsed and discarded.
  - 0x9n with d2 != 0: note=d1, velocity=d2, gate=1, note_on_pulse=1. Applies even if gate was already 1 (retrigger, last-note priority).
  - 0x8n, or 0x9n with d2=0:
    - If gate=1 and d1==note: gate=0, note_off_pulse=1.
    - Otherwise ignored.
    - note and velocity are unchanged.
  - 0xBn with d1=123 (all notes off): if gate=1, gate=0 and note_off_pulse=1. Other controllers are ignored.
  - 0xEn: pitch_bend = {d2, d1} (d2 is the MSB).
  - 0xAn, 0xCn, 0xDn: parsed for length only, no output effect.
- Latency: outputs and pulses are registered and change in the cycle after the rx_valid carrying the completing byte. Pulses last exactly one cycle.
- rx_valid is never assumed back-to-back-limited; the parser accepts a byte every cycle.
- Outputs hold between messages. The note output stays stable after note-off so the downstream step lookup stays valid during release.

Decomposition:
- Shared package (synth_pkg) holds:
  - status nibble constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, POLY_AT=4'hA, CC=4'hB, PROG=4'hC, CH_AT=4'hD, BEND=4'hE.
  - CC_ALL_NOTES_OFF=7'd123.
  - BEND_CENTRE=14'd8192.
  - parser state encoding (IDLE, WAIT_D1, WAIT_D2).
- One natural sub-module, midi_byte_classifier: combinational decode of rx_data into data / channel-status / system-common / realtime flags, plus a data-byte count (1 or 2) per status type.
- Message execution stays in midi_note_parser.

Test Plan:
- 0x90,0x3C,0x64 on channel 0 -> one cycle after the third byte: note=60, velocity=100, gate=1, single note_on_pulse.
- Running status: 0x90,0x3C,0x64,0x40,0x50 -> second note_on_pulse with note=64 and velocity=80; then 0x3C,0x00 -> ignored, gate stays 1; then 0x40,0x00 -> gate=0 and note_off_pulse.
- 0x90,0x3C,0xF8,0x64 (realtime inserted mid-message) -> identical result to the message without 0xF8; 0x91,0x3C,0x64 with CHANNEL=0 and OMNI=0 -> no output change.
- 0xE0,0x00,0x40 -> pitch_bend=8192; 0xE0,0x7F,0x7F -> pitch_bend=16383; 0xB0,0x7B,0x00 while gate=1 -> gate=0 and note_off_pulse.
- 0xF0,0x3C,0x64,0xF7,0x3C,0x64 -> no note activity (running status cleared); 0x90,0x3C then 0x80 -> partial aborted, subsequent 0x3C,0x00 acts as a note-off.
- rst_n low after 0x90,0x3C -> all outputs at reset values; post-reset 0x45,0x64 -> ignored (IDLE).
